// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared register arbiter.
// Carries request, lock and data inputs plus the grant, q, q_valid and owner results.
interface shared_reg_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     req;
  logic [N-1:0]     lock;
  logic [N*W-1:0]   wdata;
  logic [N-1:0]     gnt;
  logic [W-1:0]     q;
  logic             q_valid;
  logic [IDX_W-1:0] owner;

  modport master (output req, lock, wdata, input gnt, q, q_valid, owner);
  modport slave  (input req, lock, wdata, output gnt, q, q_valid, owner);
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter in front of one shared W-bit register.
// A locking grantee may keep the register for up to MAX_LOCK consecutive writes.
module shared_reg_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_reg_arbiter_if.slave  bus
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [N-1:0]     gnt_r, gnt_nxt_s;
  logic [W-1:0]     q_r, q_nxt_s;
  logic             q_valid_r, q_valid_nxt_s;
  logic [IDX_W-1:0] owner_r, owner_nxt_s;
  logic [IDX_W-1:0] ptr_r, ptr_nxt_s;
  logic [CNT_W-1:0] lock_cnt_r, lock_cnt_nxt_s;

  logic             rr_found_s;
  logic [IDX_W-1:0] rr_idx_s;
  logic [IDX_W-1:0] scan_s;
  logic             hold_s;
  logic [IDX_W-1:0] win_s;

  // Round-robin scan; walking offsets downward lets the closest requester to ptr win last.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = {IDX_W{1'b0}};
    scan_s     = {IDX_W{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      scan_s     = IDX_W'((int'(ptr_r) + k) % N);
      rr_found_s = rr_found_s | bus.req[scan_s];
      rr_idx_s   = bus.req[scan_s] ? scan_s : rr_idx_s;
    end
  end

  // Lock hold decision and next-state/next-output computation.
  always_comb begin
    hold_s         = (state_r != IDLE) && gnt_r[owner_r] && bus.req[owner_r] &&
                     bus.lock[owner_r] && (int'(lock_cnt_r) < (MAX_LOCK - 1));
    win_s          = hold_s ? owner_r : rr_idx_s;
    state_nxt_s    = state_r;
    gnt_nxt_s      = {N{1'b0}};
    q_nxt_s        = q_r;
    q_valid_nxt_s  = 1'b0;
    owner_nxt_s    = owner_r;
    ptr_nxt_s      = ptr_r;
    lock_cnt_nxt_s = {CNT_W{1'b0}};

    case (state_r)
      IDLE:          state_nxt_s = rr_found_s ? GRANT : IDLE;
      GRANT, LOCKED: state_nxt_s = hold_s ? LOCKED : (rr_found_s ? GRANT : IDLE);
      default:       state_nxt_s = IDLE;
    endcase

    if (hold_s || rr_found_s) begin
      gnt_nxt_s     = {{(N-1){1'b0}}, 1'b1} << win_s;
      q_nxt_s       = bus.wdata[int'(win_s) * W +: W];
      q_valid_nxt_s = 1'b1;
      owner_nxt_s   = win_s;
    end else begin
      gnt_nxt_s     = {N{1'b0}};
      q_valid_nxt_s = 1'b0;
    end

    // ptr already sits at owner+1 while a lock is held, so a lost hold rotates past the owner.
    if (hold_s) begin
      lock_cnt_nxt_s = lock_cnt_r + CNT_W'(1);
      ptr_nxt_s      = ptr_r;
    end else if (rr_found_s) begin
      lock_cnt_nxt_s = {CNT_W{1'b0}};
      ptr_nxt_s      = (rr_idx_s == IDX_W'(N - 1)) ? {IDX_W{1'b0}} : rr_idx_s + IDX_W'(1);
    end else begin
      lock_cnt_nxt_s = {CNT_W{1'b0}};
      ptr_nxt_s      = ptr_r;
    end
  end

  // Arbiter state and shared register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      gnt_r      <= {N{1'b0}};
      q_r        <= {W{1'b0}};
      q_valid_r  <= 1'b0;
      owner_r    <= {IDX_W{1'b0}};
      ptr_r      <= {IDX_W{1'b0}};
      lock_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      gnt_r      <= gnt_nxt_s;
      q_r        <= q_nxt_s;
      q_valid_r  <= q_valid_nxt_s;
      owner_r    <= owner_nxt_s;
      ptr_r      <= ptr_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.owner   = owner_r;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Randomized and directed bench for shared_reg_arbiter against a streak-counting
// round-robin reference model.
module tb_shared_reg_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shared_reg_arbiter_if #(.N(N), .W(W)) bus ();
  shared_reg_arbiter #(.N(N), .W(W), .MAX_LOCK(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: last grantee (-1 = none), consecutive grant streak, rotation start.
  int         m_last;
  int         m_streak;
  int         m_ptr;
  int         m_owner;
  logic [W-1:0] m_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_last   = -1;
    m_streak = 0;
    m_ptr    = 0;
    m_owner  = 0;
    m_q      = '0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] req, input logic [N-1:0] lock,
                                     input logic [N*W-1:0] wdata);
    int win;
    win = -1;
    if (m_last >= 0 && req[m_last] && lock[m_last] && m_streak < ML) begin
      win = m_last;
      m_streak++;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      if (win >= 0) begin
        m_ptr    = (win + 1) % N;
        m_streak = 1;
      end else begin
        m_streak = 0;
      end
    end
    m_last = win;
    if (win >= 0) begin
      m_q     = wdata[win*W +: W];
      m_owner = win;
    end
  endfunction

  task automatic check_outputs(input string tag);
    logic [N-1:0] eg;
    eg = (m_last >= 0) ? (N'(1) << m_last) : '0;
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(eg));
    check({tag, "_q"}, 32'(bus.q), 32'(m_q));
    check({tag, "_qv"}, 32'(bus.q_valid), 32'(m_last >= 0));
    check({tag, "_own"}, 32'(bus.owner), 32'(m_owner));
    check({tag, "_1hot"}, 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic cycle(input string tag, input logic [N-1:0] req, input logic [N-1:0] lock);
    bus.req  = req;
    bus.lock = lock;
    @(posedge clk);
    model_edge(bus.req, bus.lock, bus.wdata);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    check({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    check({tag, "_q"}, 32'(bus.q), 32'd0);
    check({tag, "_qv"}, 32'(bus.q_valid), 32'd0);
    check({tag, "_own"}, 32'(bus.owner), 32'd0);
    bus.req  = '0;
    bus.lock = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [N-1:0] exp2 [5];
    logic [N-1:0] exp4 [6];
    exp2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp4 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
    bus.req   = '0;
    bus.lock  = '0;
    bus.wdata = 32'h44332211;
    model_reset();
    do_reset("rst0");

    // Reset while requester 2 holds the grant, then first grant after release.
    cycle("t1a", 4'b0100, 4'b0100);
    check("t1_pre", 32'(bus.gnt), 32'b0100);
    @(negedge clk);
    do_reset("t1rst");
    cycle("t1b", 4'b1111, 4'b0000);
    check("t1_first", 32'(bus.gnt), 32'b0001);

    // Plain rotation with all requesters active.
    do_reset("t2rst");
    bus.wdata = $urandom;
    for (int i = 0; i < 5; i++) begin
      cycle("t2", 4'b1111, 4'b0000);
      check("t2_seq", 32'(bus.gnt), 32'(exp2[i]));
      check("t2_q", 32'(bus.q), 32'(bus.wdata[(i % N)*W +: W]));
    end

    // Single requester, then idle: q must hold.
    do_reset("t3rst");
    bus.wdata = 32'h00A50000;
    cycle("t3a", 4'b0100, 4'b0000);
    check("t3_q", 32'(bus.q), 32'hA5);
    check("t3_own", 32'(bus.owner), 32'd2);
    cycle("t3b", 4'b0000, 4'b0000);
    check("t3_hold", 32'(bus.q), 32'hA5);
    check("t3_qv0", 32'(bus.q_valid), 32'd0);

    // Lock limit with a competing requester.
    do_reset("t4rst");
    bus.wdata = $urandom;
    for (int i = 0; i < 6; i++) begin
      cycle("t4", 4'b0011, 4'b0001);
      check("t4_seq", 32'(bus.gnt), 32'(exp4[i]));
    end

    // Sole locking requester keeps winning across the limit.
    do_reset("t5rst");
    for (int i = 0; i < 6; i++) begin
      cycle("t5", 4'b0001, 4'b0001);
      check("t5_seq", 32'(bus.gnt), 32'b0001);
    end

    // Sparse requests.
    do_reset("t6rst");
    cycle("t6a", 4'b1000, 4'b0000);
    check("t6_a", 32'(bus.gnt), 32'b1000);
    cycle("t6b", 4'b0000, 4'b0000);
    check("t6_b", 32'(bus.gnt), 32'b0000);
    cycle("t6c", 4'b0010, 4'b0000);
    check("t6_c", 32'(bus.gnt), 32'b0010);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      bus.wdata = $urandom;
      if ($urandom_range(0, 63) == 0) begin
        do_reset("rnd_rst");
      end else begin
        cycle("rnd", N'($urandom), ($urandom_range(0, 3) != 0) ? N'($urandom) : '0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
